hazard_tag_pipe: RTL



---
 rtl/hazard_tag_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe
//
// Producer side of operand forwarding for the 5-stage pipeline. This block
// carries each instruction's write-back tag {rd, regwrite, memtoreg, prcsr}
// through ID/EX, EX/MEM and MEM/WB, and publishes those tags for the
// forwarding muxes. It also spots the dependencies that forwarding cannot
// cover, and it raises stall, bubble and flush controls for them.
//
// Ports
//   clk, reset_n                  pipeline clock, async active-low reset
//   id_valid                      ID holds a real instruction
//   id_rs1/id_rs2, id_use_rs1/2   ID source registers and whether each one is read
//   id_rd, id_regwrite,
//   id_memtoreg, id_branch,
//   id_prcsr                      ID destination and control tag
//   branch_taken                  ID-resolved redirect this cycle
//   mem_busy                      data memory not ready, so the whole pipe holds
//   stall_if, flush_ifid,
//   bubble_idex, freeze           combinational pipeline controls
//   idex_*, exmem_*, memwb_*      registered stage tags
//   stall_cnt                     saturating count of hazard-stall cycles

module hazard_tag_pipe (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memtoreg,
  input  logic        id_branch,
  input  logic [1:0]  id_prcsr,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        stall_if,
  output logic        flush_ifid,
  output logic        bubble_idex,
  output logic        freeze,
  output logic [4:0]  idex_rd,
  output logic [4:0]  exmem_rd,
  output logic [4:0]  memwb_rd,
  output logic        idex_regwrite,
  output logic        exmem_regwrite,
  output logic        memwb_regwrite,
  output logic        idex_memtoreg,
  output logic        exmem_memtoreg,
  output logic [1:0]  exmem_prcsr,
  output logic [1:0]  memwb_prcsr,
  output logic [15:0] stall_cnt
);

  logic [1:0] idex_prcsr;
  logic       idex_hit;
  logic       exmem_hit;
  logic       memwb_hit;
  logic       hazard;
  logic       stall;

  // A stage "hits" when it will write a real register that ID actually reads.
  always_comb begin
    idex_hit  = idex_regwrite && (idex_rd != 5'd0) &&
                ((id_use_rs1 && (idex_rd == id_rs1)) ||
                 (id_use_rs2 && (idex_rd == id_rs2)));
    exmem_hit = exmem_regwrite && (exmem_rd != 5'd0) &&
                ((id_use_rs1 && (exmem_rd == id_rs1)) ||
                 (id_use_rs2 && (exmem_rd == id_rs2)));
    memwb_hit = memwb_regwrite && (memwb_rd != 5'd0) &&
                ((id_use_rs1 && (memwb_rd == id_rs1)) ||
                 (id_use_rs2 && (memwb_rd == id_rs2)));
  end

  // Dependencies that no forwarding path resolves. A load feeding a branch
  // shows up twice as the load moves from ID/EX to EX/MEM, which gives that
  // case its two-cycle stall. A non-forwardable (prcsr != 0) producer blocks
  // its consumer until the producer leaves MEM/WB.
  always_comb begin
    hazard = (idex_hit && idex_memtoreg) ||
             (idex_hit && id_branch) ||
             (exmem_hit && exmem_memtoreg && id_branch) ||
             (idex_hit && (idex_prcsr != 2'd0)) ||
             (exmem_hit && (exmem_prcsr != 2'd0)) ||
             (memwb_hit && (memwb_prcsr != 2'd0));
  end

  // Mode priority is freeze, then flush, then stall. Every control is forced
  // low while reset is asserted, even when mem_busy or branch_taken is high.
  always_comb begin
    freeze      = reset_n && mem_busy;
    flush_ifid  = reset_n && !mem_busy && branch_taken;
    stall       = reset_n && !mem_busy && !branch_taken && hazard;
    stall_if    = freeze || stall;
    bubble_idex = stall;
  end

  // Tag pipe. A freeze holds every stage. Otherwise the tags shift by one
  // stage. ID/EX takes a NOP for a bubble or an empty ID slot. A write to x0
  // keeps its rd but loses all write-back effects, so it can never match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_rd        <= 5'd0;
      idex_regwrite  <= 1'b0;
      idex_memtoreg  <= 1'b0;
      idex_prcsr     <= 2'd0;
      exmem_rd       <= 5'd0;
      exmem_regwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_prcsr    <= 2'd0;
      memwb_rd       <= 5'd0;
      memwb_regwrite <= 1'b0;
      memwb_prcsr    <= 2'd0;
    end else if (!mem_busy) begin
      memwb_rd       <= exmem_rd;
      memwb_regwrite <= exmem_regwrite;
      memwb_prcsr    <= exmem_prcsr;
      exmem_rd       <= idex_rd;
      exmem_regwrite <= idex_regwrite;
      exmem_memtoreg <= idex_memtoreg;
      exmem_prcsr    <= idex_prcsr;
      if (bubble_idex || !id_valid) begin
        idex_rd       <= 5'd0;
        idex_regwrite <= 1'b0;
        idex_memtoreg <= 1'b0;
        idex_prcsr    <= 2'd0;
      end else if (id_regwrite && (id_rd == 5'd0)) begin
        idex_rd       <= id_rd;
        idex_regwrite <= 1'b0;
        idex_memtoreg <= 1'b0;
        idex_prcsr    <= 2'd0;
      end else begin
        idex_rd       <= id_rd;
        idex_regwrite <= id_regwrite;
        idex_memtoreg <= id_memtoreg;
        idex_prcsr    <= id_prcsr;
      end
    end
  end

  // Count the cycles lost to hazards. The counter sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
